// File: rtl/ram_sp_arbiter_if.sv
// Requester-side bundle of the shared RAM arbiter: access request, accept, and
// the shared read-response bus. master = requesters, slave = arbiter.
interface ram_sp_arbiter_if #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_WIDTH = 8
);
  localparam int SW = DATA_WIDTH / BYTE_WIDTH;

  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ-1:0][SW-1:0]         req_strobe;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]                 req_ready;
  logic [N_REQ-1:0]                 resp_valid;
  logic [DATA_WIDTH-1:0]            resp_rdata;

  modport master (
    output req_valid, req_addr, req_strobe, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_strobe, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/ram_sp_arbiter.sv
// Round-robin arbiter sharing one single-port RAM; grant is combinational (0 cycles),
// responses return READ_LATENCY cycles after grant with no backpressure on them.
module ram_sp_arbiter #(
  parameter int N_REQ        = 2,
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 64,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  localparam int SW          = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  ram_sp_arbiter_if.slave       bus,
  output logic                  o_mem_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [SW-1:0]         o_mem_strobe,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int L  = READ_LATENCY;

  logic [IW-1:0]    r_ptr;
  logic             w_grant;
  logic [IW-1:0]    w_winner;
  logic [IW-1:0]    w_idx;
  logic [N_REQ-1:0] w_ready;

  // First valid requester scanning upward from the priority pointer.
  always_comb begin
    w_grant  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % N_REQ);
      if (!w_grant && bus.req_valid[w_idx]) begin
        w_grant  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Gating with the reset input keeps the RAM idle while reset is held.
  always_comb begin
    w_ready = '0;
    if (w_grant && i_resetn) w_ready[w_winner] = 1'b1;
  end

  assign bus.req_ready  = w_ready;
  assign o_mem_en       = |w_ready;
  assign bus.resp_rdata = i_mem_rdata;

  always_comb begin
    o_mem_addr   = '0;
    o_mem_strobe = '0;
    o_mem_wdata  = '0;
    if (|w_ready) begin
      o_mem_addr   = bus.req_addr[w_winner];
      o_mem_strobe = bus.req_strobe[w_winner];
      o_mem_wdata  = bus.req_wdata[w_winner];
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_ptr <= '0;
    end else if (|w_ready) begin
      r_ptr <= (w_winner == IW'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
    end
  end

  generate
    if (L == 0) begin : g_comb_resp
      assign bus.resp_valid = w_ready;
    end else begin : g_tag_pipe
      // Owner tags travel alongside the RAM read pipeline.
      logic [L-1:0]         r_tag_vld;
      logic [L-1:0][IW-1:0] r_tag_own;

      always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
          r_tag_vld <= '0;
          r_tag_own <= '0;
        end else begin
          r_tag_vld[0] <= |w_ready;
          r_tag_own[0] <= w_winner;
          for (int k = 1; k < L; k++) begin
            r_tag_vld[k] <= r_tag_vld[k-1];
            r_tag_own[k] <= r_tag_own[k-1];
          end
        end
      end

      always_comb begin
        bus.resp_valid = '0;
        if (r_tag_vld[L-1]) bus.resp_valid[r_tag_own[L-1]] = 1'b1;
      end
    end
  endgenerate
endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter: four instances (N_REQ=3, READ_LATENCY=0..3), each with a
// read-first RAM model, checked against a queue-based reference of the arbiter.
module tb_ram_sp_arbiter;
  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int SW = DW / BW;
  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]           rstn;
  logic [N-1:0]            tb_vld  [NI];
  logic [N-1:0][AW-1:0]    tb_addr [NI];
  logic [N-1:0][SW-1:0]    tb_strb [NI];
  logic [N-1:0][DW-1:0]    tb_wdat [NI];
  logic [N-1:0]            ob_rdy  [NI];
  logic [N-1:0]            ob_rv   [NI];
  logic [DW-1:0]           ob_rd   [NI];
  logic                    ob_en   [NI];
  logic [AW-1:0]           ob_addr [NI];
  logic [SW-1:0]           ob_strb [NI];
  logic [DW-1:0]           ob_wdat [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_inst
      ram_sp_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();
      logic [DW-1:0] mem_rdata;
      logic [DW-1:0] ram   [16];
      logic [DW-1:0] rpipe [4];

      assign bus.req_valid  = tb_vld[g];
      assign bus.req_addr   = tb_addr[g];
      assign bus.req_strobe = tb_strb[g];
      assign bus.req_wdata  = tb_wdat[g];
      assign ob_rdy[g]      = bus.req_ready;
      assign ob_rv[g]       = bus.resp_valid;
      assign ob_rd[g]       = bus.resp_rdata;

      ram_sp_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .READ_LATENCY(g)
      ) u_dut (
        .i_clk        (clk),
        .i_resetn     (rstn[g]),
        .bus          (bus),
        .o_mem_en     (ob_en[g]),
        .o_mem_addr   (ob_addr[g]),
        .o_mem_strobe (ob_strb[g]),
        .o_mem_wdata  (ob_wdat[g]),
        .i_mem_rdata  (mem_rdata)
      );

      initial for (int i = 0; i < 16; i++) ram[i] = '0;

      // Read-first single-port RAM
      always @(posedge clk) begin
        if (ob_en[g]) begin
          rpipe[0] <= ram[ob_addr[g][3:0]];
          for (int b = 0; b < SW; b++)
            if (ob_strb[g][b]) ram[ob_addr[g][3:0]][b*BW +: BW] <= ob_wdat[g][b*BW +: BW];
        end
        for (int k = 1; k < 4; k++) rpipe[k] <= rpipe[k-1];
      end

      if (g == 0) begin : g_l0
        assign mem_rdata = ram[ob_addr[g][3:0]];
      end else begin : g_ln
        assign mem_rdata = rpipe[g-1];
      end
    end
  endgenerate

  typedef struct {
    int            due;
    int            owner;
    logic [DW-1:0] data;
  } resp_t;

  resp_t                rq [$];
  int                   mptr [NI];
  logic [DW-1:0]        mmem [NI][16];
  int                   cyc;
  int                   n_tests;
  int                   n_fail;
  int                   obs_grant [$];
  int                   obs_resp  [$];
  logic [N-1:0]         last_rv;
  logic [DW-1:0]        last_rd;
  logic [N-1:0]         p_vld;
  logic [N-1:0][AW-1:0] p_addr;
  logic [N-1:0][SW-1:0] p_strb;
  logic [N-1:0][DW-1:0] p_wdat;

  task automatic drive(input int inst);
    tb_vld[inst]  = p_vld;
    tb_addr[inst] = p_addr;
    tb_strb[inst] = p_strb;
    tb_wdat[inst] = p_wdat;
  endtask

  // One clock cycle on instance inst; latency of instance inst is inst cycles.
  task automatic run_cycle(input int inst);
    int            w;
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  exp_rv;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] exp_addr;
    logic [SW-1:0] exp_strb;
    logic [DW-1:0] exp_wdat;
    logic [3:0]    a;
    resp_t         r;
    drive(inst);
    #1;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && p_vld[(mptr[inst] + k) % N]) w = (mptr[inst] + k) % N;
    exp_rdy  = '0;
    exp_addr = '0;
    exp_strb = '0;
    exp_wdat = '0;
    if (w >= 0) begin
      exp_rdy[w] = 1'b1;
      exp_addr   = p_addr[w];
      exp_strb   = p_strb[w];
      exp_wdat   = p_wdat[w];
    end
    for (int j = 0; j < N; j++) if (ob_rdy[inst][j]) obs_grant.push_back(j);
    n_tests++;
    if (ob_rdy[inst] !== exp_rdy) begin
      n_fail++;
      $display("FAIL ready inst=%0d cyc=%0d got=%b exp=%b", inst, cyc, ob_rdy[inst], exp_rdy);
    end
    n_tests++;
    if (ob_en[inst] !== (w >= 0)) begin
      n_fail++;
      $display("FAIL mem_en inst=%0d cyc=%0d got=%b exp=%b", inst, cyc, ob_en[inst], (w >= 0));
    end
    n_tests++;
    if ({ob_addr[inst], ob_strb[inst], ob_wdat[inst]} !== {exp_addr, exp_strb, exp_wdat}) begin
      n_fail++;
      $display("FAIL mem_bus inst=%0d cyc=%0d got=%h/%h/%h exp=%h/%h/%h", inst, cyc,
               ob_addr[inst], ob_strb[inst], ob_wdat[inst], exp_addr, exp_strb, exp_wdat);
    end
    if (w >= 0) begin
      a       = p_addr[w][3:0];
      r.due   = cyc + inst;
      r.owner = w;
      r.data  = mmem[inst][a];
      rq.push_back(r);
      for (int b = 0; b < SW; b++)
        if (p_strb[w][b]) mmem[inst][a][b*BW +: BW] = p_wdat[w][b*BW +: BW];
      mptr[inst] = (w + 1) % N;
      p_vld[w]   = 1'b0;
    end
    exp_rv = '0;
    exp_rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      exp_rv[r.owner] = 1'b1;
      exp_rd = r.data;
    end
    for (int j = 0; j < N; j++) if (ob_rv[inst][j]) obs_resp.push_back(j);
    if (ob_rv[inst] != '0) begin
      last_rv = ob_rv[inst];
      last_rd = ob_rd[inst];
    end
    n_tests++;
    if (ob_rv[inst] !== exp_rv) begin
      n_fail++;
      $display("FAIL resp_valid inst=%0d cyc=%0d got=%b exp=%b", inst, cyc, ob_rv[inst], exp_rv);
    end
    if (exp_rv != '0) begin
      n_tests++;
      if (ob_rd[inst] !== exp_rd) begin
        n_fail++;
        $display("FAIL resp_rdata inst=%0d cyc=%0d got=%h exp=%h", inst, cyc, ob_rd[inst], exp_rd);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int inst, input int n);
    p_vld = '0;
    repeat (n) run_cycle(inst);
  endtask

  task automatic check_drained(input int inst);
    n_tests++;
    if (rq.size() != 0) begin
      n_fail++;
      $display("FAIL drained inst=%0d got=%0d pending responses exp=0", inst, rq.size());
    end
  endtask

  task automatic set_req(input int j, input logic [AW-1:0] addr, input logic [SW-1:0] strb,
                         input logic [DW-1:0] wdat);
    p_vld[j]  = 1'b1;
    p_addr[j] = addr;
    p_strb[j] = strb;
    p_wdat[j] = wdat;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      tb_vld[i]  = '1;
      tb_addr[i] = '0;
      tb_strb[i] = '0;
      tb_wdat[i] = '0;
    end
    rstn = '0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) #2;
      else begin
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (ob_rdy[i] !== '0 || ob_en[i] !== 1'b0 || ob_rv[i] !== '0) begin
          n_fail++;
          $display("FAIL in_reset inst=%0d got=rdy %b en %b rv %b exp=all zero",
                   i, ob_rdy[i], ob_en[i], ob_rv[i]);
        end
      end
    end
    for (int i = 0; i < NI; i++) tb_vld[i] = '0;
    rstn = '1;
  endtask

  task automatic test_fairness();
    int exp_seq [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    obs_grant.delete();
    obs_resp.delete();
    p_vld = '0;
    for (int c = 0; c < 9; c++) begin
      for (int j = 0; j < N; j++)
        if (!p_vld[j]) set_req(j, AW'($urandom_range(0, 15)), '0, '0);
      run_cycle(1);
    end
    idle(1, 3);
    for (int c = 0; c < 9; c++) begin
      n_tests++;
      if (c >= obs_grant.size() || obs_grant[c] != exp_seq[c]) begin
        n_fail++;
        $display("FAIL fair_grant slot=%0d got=%0d exp=%0d", c,
                 (c < obs_grant.size()) ? obs_grant[c] : -1, exp_seq[c]);
      end
      n_tests++;
      if (c >= obs_resp.size() || obs_resp[c] != exp_seq[c]) begin
        n_fail++;
        $display("FAIL fair_resp slot=%0d got=%0d exp=%0d", c,
                 (c < obs_resp.size()) ? obs_resp[c] : -1, exp_seq[c]);
      end
    end
    check_drained(1);
  endtask

  task automatic test_single_read();
    p_vld = '0;
    set_req(1, 10'd5, '1, 64'h0123_4567_89AB_CDEF);
    run_cycle(1);
    idle(1, 2);
    last_rv = '0;
    last_rd = '0;
    set_req(0, 10'd5, '0, '0);
    run_cycle(1);
    idle(1, 1);
    n_tests++;
    if (last_rv !== 3'b001 || last_rd !== 64'h0123_4567_89AB_CDEF) begin
      n_fail++;
      $display("FAIL single_read got=%b/%h exp=001/0123456789abcdef", last_rv, last_rd);
    end
  endtask

  task automatic test_write_read();
    p_vld   = '0;
    last_rv = '0;
    last_rd = 'x;
    set_req(1, 10'd3, 8'hFF, 64'hA5A5);
    run_cycle(1);
    idle(1, 1);
    n_tests++;
    if (last_rv !== 3'b010 || last_rd !== 64'h0) begin
      n_fail++;
      $display("FAIL write_old_data got=%b/%h exp=010/0", last_rv, last_rd);
    end
    last_rv = '0;
    set_req(1, 10'd3, '0, '0);
    run_cycle(1);
    idle(1, 1);
    n_tests++;
    if (last_rv !== 3'b010 || last_rd !== 64'hA5A5) begin
      n_fail++;
      $display("FAIL read_after_write got=%b/%h exp=010/a5a5", last_rv, last_rd);
    end
  endtask

  task automatic test_partial_strobe();
    p_vld = '0;
    set_req(0, 10'd7, 8'h01, 64'hFFFF_FFFF);
    run_cycle(1);
    idle(1, 1);
    last_rv = '0;
    set_req(0, 10'd7, '0, '0);
    run_cycle(1);
    idle(1, 1);
    n_tests++;
    if (last_rv !== 3'b001 || last_rd !== 64'h0000_0000_0000_00FF) begin
      n_fail++;
      $display("FAIL partial_strobe got=%b/%h exp=001/00000000000000ff", last_rv, last_rd);
    end
  endtask

  task automatic test_reset_midflight();
    p_vld = '0;
    set_req(0, 10'd1, '0, '0);
    run_cycle(2);
    set_req(1, 10'd2, '0, '0);
    run_cycle(2);
    n_tests++;
    if (ob_rv[2] !== 3'b001) begin
      n_fail++;
      $display("FAIL pre_reset_resp got=%b exp=001", ob_rv[2]);
    end
    for (int j = 0; j < N; j++) set_req(j, AW'(j + 8), '0, '0);
    drive(2);
    rstn[2] = 1'b0;
    #1;
    n_tests++;
    if (ob_rv[2] !== '0 || ob_rdy[2] !== '0 || ob_en[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got=rv %b rdy %b en %b exp=all zero", ob_rv[2], ob_rdy[2], ob_en[2]);
    end
    rq.delete();
    mptr[2] = 0;
    @(posedge clk);
    #1;
    cyc++;
    n_tests++;
    if (ob_rv[2] !== '0 || ob_rdy[2] !== '0) begin
      n_fail++;
      $display("FAIL reset_held got=rv %b rdy %b exp=all zero", ob_rv[2], ob_rdy[2]);
    end
    rstn[2] = 1'b1;
    idle(2, 4);
    obs_grant.delete();
    for (int j = 0; j < N; j++) set_req(j, AW'(j + 8), '0, '0);
    run_cycle(2);
    n_tests++;
    if (obs_grant.size() != 1 || obs_grant[0] != 0) begin
      n_fail++;
      $display("FAIL ptr_after_reset got=%0d grants first=%0d exp=1 grant to 0",
               obs_grant.size(), (obs_grant.size() > 0) ? obs_grant[0] : -1);
    end
    idle(2, 4);
    check_drained(2);
  endtask

  task automatic test_latency_sweep();
    int insts [3] = '{0, 1, 3};
    for (int t = 0; t < 3; t++) begin
      p_vld = '0;
      for (int c = 0; c < 150; c++) begin
        for (int j = 0; j < N; j++)
          if (!p_vld[j] && $urandom_range(0, 3) != 0)
            set_req(j, AW'($urandom_range(0, 15)),
                    ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0, {$urandom, $urandom});
        run_cycle(insts[t]);
      end
      idle(insts[t], 5);
      check_drained(insts[t]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    p_vld   = '0;
    p_addr  = '0;
    p_strb  = '0;
    p_wdat  = '0;
    last_rv = '0;
    last_rd = '0;
    for (int i = 0; i < NI; i++) begin
      mptr[i] = 0;
      for (int a = 0; a < 16; a++) mmem[i][a] = '0;
    end
    test_reset();
    test_fairness();
    test_single_read();
    test_write_read();
    test_partial_strobe();
    test_reset_midflight();
    test_latency_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
